// File: rtl/redirect_ctrl.sv
// Fetch redirect arbiter: grants trap/branch/jump redirects by fixed priority
// and tracks the delay-line flush so valid_out marks when fetched data is real.
module redirect_ctrl #(
    parameter int M = 3,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         trap_req,
    input  logic [N-1:0] trap_target,
    input  logic         br_req,
    input  logic [N-1:0] br_target,
    input  logic         jmp_req,
    input  logic [N-1:0] jmp_target,
    input  logic         stall,
    output logic         trap_ack,
    output logic         br_ack,
    output logic         jmp_ack,
    output logic         reload_en,
    output logic [N-1:0] reload_data,
    output logic         valid_out,
    output logic         busy,
    output logic [1:0]   last_src,
    output logic [15:0]  redirect_cnt
);

    localparam int CW = $clog2(M + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic            trap_go_s;
    logic            br_go_s;
    logic            jmp_go_s;
    logic [1:0]      grant_src_s;
    logic [N-1:0]    grant_tgt_s;

    // A requester acked this cycle is masked so a held request is not regranted at once.
    always_comb begin
        trap_go_s = trap_req & ~trap_ack;
        br_go_s   = br_req & ~br_ack;
        jmp_go_s  = jmp_req & ~jmp_ack;
    end

    // Fixed-priority winner; only a trap may preempt an ongoing flush.
    always_comb begin
        grant_src_s = 2'b00;
        grant_tgt_s = {N{1'b0}};
        if (stall) begin
            grant_src_s = 2'b00;
        end else if (trap_go_s) begin
            grant_src_s = 2'b01;
            grant_tgt_s = trap_target;
        end else if ((state_r == IDLE) && br_go_s) begin
            grant_src_s = 2'b10;
            grant_tgt_s = br_target;
        end else if ((state_r == IDLE) && jmp_go_s) begin
            grant_src_s = 2'b11;
            grant_tgt_s = jmp_target;
        end else begin
            grant_src_s = 2'b00;
        end
    end

    // Arbitration FSM with registered grant pulses and flush countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= FLUSH;
            cnt_r        <= CW'(M);
            valid_out    <= 1'b0;
            busy         <= 1'b1;
            reload_en    <= 1'b0;
            reload_data  <= {N{1'b0}};
            trap_ack     <= 1'b0;
            br_ack       <= 1'b0;
            jmp_ack      <= 1'b0;
            last_src     <= 2'b00;
            redirect_cnt <= 16'd0;
        end else begin
            trap_ack  <= (grant_src_s == 2'b01);
            br_ack    <= (grant_src_s == 2'b10);
            jmp_ack   <= (grant_src_s == 2'b11);
            reload_en <= (grant_src_s != 2'b00);
            if (grant_src_s != 2'b00) begin
                reload_data  <= grant_tgt_s;
                last_src     <= grant_src_s;
                redirect_cnt <= redirect_cnt + 16'd1;
                state_r      <= FLUSH;
                cnt_r        <= CW'(M);
                valid_out    <= 1'b0;
                busy         <= 1'b1;
            end else if (!stall && (state_r == FLUSH)) begin
                if (cnt_r == CW'(1)) begin
                    state_r   <= IDLE;
                    valid_out <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    cnt_r <= cnt_r - CW'(1);
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: doc/redirect_ctrl.md
REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 Parameter: M, 3, delay-line depth in stages (M >= 1).
REQ-002 Parameter: N, 32, address/data width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: trap_req / trap_target  input  1 / N  trap redirect request and target.
REQ-006 Port: br_req / br_target  input  1 / N  branch redirect request and target.
REQ-007 Port: jmp_req / jmp_target  input  1 / N  jump redirect request and target.
REQ-008 Port: stall  input  1  freezes arbitration and flush countdown.
REQ-009 Port: trap_ack, br_ack, jmp_ack  output  1 each  one-cycle grant pulses.
REQ-010 Port: reload_en / reload_data  output  1 / N  delay-line preload strobe and target.
REQ-011 Port: valid_out  output  1  delay-line output carries real data.
REQ-012 Port: busy  output  1  high while in FLUSH.
REQ-013 Port: last_src  output  2  source of last grant: 00 none, 01 trap, 10 branch, 11 jump.
REQ-014 Port: redirect_cnt  output  16  count of grants, wraps at 16'hFFFF -> 0.

Function
REQ-015 All outputs SHALL be registered; no combinational input-to-output path.
REQ-016 FSM SHALL have exactly two states: IDLE and FLUSH; a down-counter cnt of width clog2(M+1) SHALL accompany FLUSH.
REQ-017 Priority SHALL be fixed: trap > branch > jump.
REQ-018 A requester whose ack is high in the current cycle SHALL be masked at that edge (no double grant from a held req).
REQ-019 IDLE, stall=0, any unmasked req at edge E: grant winner; next cycle reload_en=1, reload_data=winner target, winner ack=1, last_src updated, redirect_cnt+1, state FLUSH, cnt=M, valid_out=0.
REQ-020 IDLE with stall=1: no grant, no state change; requests stay pending.
REQ-021 reload_en and every ack SHALL be single-cycle pulses; reload_data SHALL hold its last value until the next grant.
REQ-022 FLUSH, stall=0, no unmasked trap_req: cnt decrements each edge; at the edge where cnt==1, state IDLE and valid_out=1.
REQ-023 FLUSH with stall=1: cnt, state and valid_out frozen; no grants, trap included.
REQ-024 FLUSH, stall=0, unmasked trap_req: trap preempts; regrant per REQ-019 (cnt reloaded to M, valid_out stays 0).
REQ-025 Branch and jump requests during FLUSH SHALL wait; they are granted no earlier than the edge after valid_out returns to 1.
REQ-026 Simultaneous requests: only the highest-priority one granted; losers keep req asserted and are granted in later IDLE cycles.
REQ-027 busy SHALL equal (state==FLUSH) as a registered signal; valid_out SHALL equal !busy.
REQ-028 With no stall, valid_out SHALL be low for exactly M cycles after each grant edge.

Reset
REQ-029 rst_n low SHALL immediately force: state FLUSH, cnt=M, valid_out=0, busy=1, reload_en=0, all acks 0, reload_data=0, last_src=00, redirect_cnt=0.
REQ-030 After rst_n release, FLUSH SHALL count down per REQ-022 so valid_out rises after M unstalled edges (delay line contents undefined until then).
REQ-031 rst_n assertion mid-FLUSH or during an ack cycle SHALL abort the operation; no ack or reload_en pulse emitted after reset release for the aborted request.

Verification (M=3, N=32)
REQ-032 Release rst_n, no reqs, stall=0 -> valid_out 0 for 3 cycles, 1 on 4th; busy mirrors inverted.
REQ-033 IDLE, br_req=1 br_target=0x100 at edge 0 -> cycle 1: reload_en=1, reload_data=0x100, br_ack=1, last_src=10, redirect_cnt=1; valid_out 0 cycles 1-3, 1 at cycle 4.
REQ-034 IDLE, trap/br/jmp all req same edge (targets 0x10/0x20/0x30) -> trap granted (0x10), then branch (0x20) after flush, then jump (0x30); redirect_cnt=3, last_src=11.
REQ-035 br granted, trap_req (target 0x200) raised 1 cycle into FLUSH -> second reload_en with 0x200, trap_ack, cnt restarted; valid_out low 3 cycles from that edge.
REQ-036 stall=1 for 2 cycles mid-FLUSH -> valid_out rise delayed by exactly 2 cycles; stall in IDLE with jmp_req -> no ack until stall drops.
REQ-037 rst_n pulsed low during a FLUSH with redirect_cnt=5 -> all outputs to REQ-029 values asynchronously; post-release behaviour as REQ-032.
